// File: rtl/osd_pkg.sv
// Shared OSD definitions: mixing modes used by the window mixer and the
// OSD register-file block.
package osd_pkg;

   typedef enum logic [1:0] {
      OSD_MODE_OPAQUE = 2'd0,
      OSD_MODE_BLEND  = 2'd1,
      OSD_MODE_KEY    = 2'd2,
      OSD_MODE_RSVD   = 2'd3
   } osd_mode_e;

endpackage

// File: rtl/osd_delay_line.sv
// Stallable fixed-depth delay line with a programmable reset word.
// DEPTH = 0 degenerates to a plain wire.
module osd_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk_pixel,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] RST_VALUE,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ctrl;
         assign unused_ctrl = ^{clk_pixel, rst, ena, RST_VALUE};
         assign out = in;
      end else begin : g_pipe
         logic [DEPTH-1:0][WIDTH-1:0] tap_q;

         // shift one tap per enabled pixel
         always_ff @(posedge clk_pixel) begin
            if (rst) begin
               tap_q <= {DEPTH{RST_VALUE}};
            end else if (ena) begin
               tap_q[0] <= in;
               for (int i = 1; i < DEPTH; i++) tap_q[i] <= tap_q[i-1];
            end
         end

         assign out = tap_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/osd_window_mixer.sv
// OSD window overlay stage: raster tracking, window-relative coordinates to an
// external OSD source, and opaque/blend/key mixing realigned to the video.
module osd_window_mixer
   import osd_pkg::*;
#(
   parameter int C_color_bits  = 8,
   parameter int C_x_bits      = 11,
   parameter int C_y_bits      = 11,
   parameter int C_src_latency = 1
) (
   input  logic                      clk_pixel,
   input  logic                      rst,
   input  logic                      clk_pixel_ena,
   input  logic [C_color_bits-1:0]   i_r,
   input  logic [C_color_bits-1:0]   i_g,
   input  logic [C_color_bits-1:0]   i_b,
   input  logic                      i_hsync,
   input  logic                      i_vsync,
   input  logic                      i_blank,
   input  logic [C_x_bits-1:0]       cfg_x_start,
   input  logic [C_x_bits-1:0]       cfg_x_stop,
   input  logic [C_y_bits-1:0]       cfg_y_start,
   input  logic [C_y_bits-1:0]       cfg_y_stop,
   input  logic                      cfg_en,
   input  logic [1:0]                cfg_mode,
   input  logic [3*C_color_bits-1:0] cfg_key,
   output logic [C_x_bits-1:0]       o_osd_x,
   output logic [C_y_bits-1:0]       o_osd_y,
   output logic                      o_osd_valid,
   input  logic [C_color_bits-1:0]   i_osd_r,
   input  logic [C_color_bits-1:0]   i_osd_g,
   input  logic [C_color_bits-1:0]   i_osd_b,
   output logic [C_color_bits-1:0]   o_r,
   output logic [C_color_bits-1:0]   o_g,
   output logic [C_color_bits-1:0]   o_b,
   output logic                      o_hsync,
   output logic                      o_vsync,
   output logic                      o_blank
);

   localparam int CB = C_color_bits;
   localparam int DW = 3*CB + 4;
   localparam logic [DW-1:0] DL_RST = DW'(2);  // blank=1, in_win=0

   // stage 0: raster counters and frame-start shadows
   logic [C_x_bits-1:0]  x_cnt_q, x_cnt_d, sh_xs_q, sh_xe_q, xs, xe, osd_x_q;
   logic [C_y_bits-1:0]  y_cnt_q, y_cnt_d, y_cur, sh_ys_q, sh_ye_q, ys, ye, osd_y_q;
   logic                 act_q, vs_q, vs_rise, sh_en_q, win_en, in_win, osd_vld_q;
   osd_mode_e            sh_mode_q;
   logic [3*CB-1:0]      sh_key_q;

   // A vsync edge coinciding with a pixel must already use the new frame's
   // window and row 0, so the shadow inputs are bypassed on that cycle.
   assign vs_rise = i_vsync & ~vs_q;
   assign xs      = vs_rise ? cfg_x_start : sh_xs_q;
   assign xe      = vs_rise ? cfg_x_stop  : sh_xe_q;
   assign ys      = vs_rise ? cfg_y_start : sh_ys_q;
   assign ye      = vs_rise ? cfg_y_stop  : sh_ye_q;
   assign win_en  = vs_rise ? cfg_en      : sh_en_q;
   assign y_cur   = vs_rise ? '0          : y_cnt_q;

   assign in_win = ~i_blank & win_en & (x_cnt_q >= xs) & (x_cnt_q < xe) &
                   (y_cur >= ys) & (y_cur < ye);

   // saturating counter next-state
   always_comb begin
      x_cnt_d = x_cnt_q;
      y_cnt_d = y_cnt_q;
      if (i_blank)              x_cnt_d = '0;
      else if (x_cnt_q != '1)   x_cnt_d = x_cnt_q + 1'b1;
      if (vs_rise)              y_cnt_d = '0;
      else if (act_q && i_blank && y_cnt_q != '1) y_cnt_d = y_cnt_q + 1'b1;
   end

   // counters, shadows and the coordinate register
   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         x_cnt_q   <= '0;
         y_cnt_q   <= '0;
         act_q     <= 1'b0;
         vs_q      <= 1'b0;
         sh_xs_q   <= '0;
         sh_xe_q   <= '0;
         sh_ys_q   <= '0;
         sh_ye_q   <= '0;
         sh_en_q   <= 1'b0;
         sh_mode_q <= OSD_MODE_OPAQUE;
         sh_key_q  <= '0;
         osd_x_q   <= '0;
         osd_y_q   <= '0;
         osd_vld_q <= 1'b0;
      end else if (clk_pixel_ena) begin
         x_cnt_q <= x_cnt_d;
         y_cnt_q <= y_cnt_d;
         act_q   <= ~i_blank;
         vs_q    <= i_vsync;
         if (vs_rise) begin
            sh_xs_q   <= cfg_x_start;
            sh_xe_q   <= cfg_x_stop;
            sh_ys_q   <= cfg_y_start;
            sh_ye_q   <= cfg_y_stop;
            sh_en_q   <= cfg_en;
            sh_mode_q <= osd_mode_e'(cfg_mode);
            sh_key_q  <= cfg_key;
         end
         osd_vld_q <= in_win;
         osd_x_q   <= in_win ? x_cnt_q - xs : '0;
         osd_y_q   <= in_win ? y_cur - ys   : '0;
      end
   end

   assign o_osd_x     = osd_x_q;
   assign o_osd_y     = osd_y_q;
   assign o_osd_valid = osd_vld_q;

   // realign video and window flag with the OSD source return
   logic [DW-1:0]   dl_out;
   logic [CB-1:0]   d_r, d_g, d_b;
   logic            d_hs, d_vs, d_blank, d_win;

   osd_delay_line #(.WIDTH(DW), .DEPTH(1 + C_src_latency)) u_dly (
      .clk_pixel (clk_pixel),
      .rst       (rst),
      .ena       (clk_pixel_ena),
      .RST_VALUE (DL_RST),
      .in        ({i_r, i_g, i_b, i_hsync, i_vsync, i_blank, in_win}),
      .out       (dl_out)
   );

   assign {d_r, d_g, d_b, d_hs, d_vs, d_blank, d_win} = dl_out;

   // mixing
   logic [CB:0]   sum_r, sum_g, sum_b;
   logic [CB-1:0] mix_r, mix_g, mix_b;
   logic [CB-1:0] r_q, g_q, b_q;
   logic          hs_q, vs_o_q, blank_q;

   assign sum_r = {1'b0, d_r} + {1'b0, i_osd_r};
   assign sum_g = {1'b0, d_g} + {1'b0, i_osd_g};
   assign sum_b = {1'b0, d_b} + {1'b0, i_osd_b};

   // select overlay colour inside the window, pass video elsewhere
   always_comb begin
      mix_r = d_r;
      mix_g = d_g;
      mix_b = d_b;
      if (d_win) begin
         case (sh_mode_q)
            OSD_MODE_BLEND: begin
               mix_r = sum_r[CB:1];
               mix_g = sum_g[CB:1];
               mix_b = sum_b[CB:1];
            end
            OSD_MODE_KEY: begin
               if ({i_osd_r, i_osd_g, i_osd_b} != sh_key_q) begin
                  mix_r = i_osd_r;
                  mix_g = i_osd_g;
                  mix_b = i_osd_b;
               end
            end
            default: begin
               mix_r = i_osd_r;
               mix_g = i_osd_g;
               mix_b = i_osd_b;
            end
         endcase
      end
   end

   // output register
   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         hs_q    <= 1'b0;
         vs_o_q  <= 1'b0;
         blank_q <= 1'b1;
      end else if (clk_pixel_ena) begin
         r_q     <= mix_r;
         g_q     <= mix_g;
         b_q     <= mix_b;
         hs_q    <= d_hs;
         vs_o_q  <= d_vs;
         blank_q <= d_blank;
      end
   end

   assign o_r     = r_q;
   assign o_g     = g_q;
   assign o_b     = b_q;
   assign o_hsync = hs_q;
   assign o_vsync = vs_o_q;
   assign o_blank = blank_q;

endmodule

// File: doc/osd_window_mixer.md
Name: osd_window_mixer

Overview:
- Parametrised successor to the fixed-window OSD overlay stage between the video source and the HDMI/DVI encoder.
- Tracks raster position from sync/blank and exposes window-relative coordinates to an external OSD pixel source (e.g. hex decoder) of configurable latency.
- Mixes the returned OSD colour into the video in opaque, 50% blend or colour-key mode, with timing fully realigned.
- Window geometry, enable and mode are runtime ports, shadowed at frame start.

Parameters:
- C_color_bits, 8, bits per colour channel on all RGB ports.
- C_x_bits, 11, width of horizontal counter and x config/coordinate ports.
- C_y_bits, 11, width of vertical counter and y config/coordinate ports.
- C_src_latency, 1, cycles from o_osd_x/o_osd_y to matching i_osd_rgb; legal 0..8.

Ports:
- clk_pixel  in  1  pixel clock; single clock domain.
- rst  in  1  reset, synchronous to clk_pixel, active-high.
- clk_pixel_ena  in  1  pixel qualifier; 0 stalls every register.
- i_r, i_g, i_b  in  C_color_bits each  input video.
- i_hsync, i_vsync, i_blank  in  1 each  input timing; active-high sync.
- cfg_x_start, cfg_x_stop  in  C_x_bits each  window columns, [start, stop).
- cfg_y_start, cfg_y_stop  in  C_y_bits each  window rows, [start, stop).
- cfg_en  in  1  overlay enable.
- cfg_mode  in  2  0 opaque, 1 blend, 2 key, 3 reserved (treated as opaque).
- cfg_key  in  3*C_color_bits  key colour {r,g,b} for key mode.
- o_osd_x  out  C_x_bits  x relative to window start.
- o_osd_y  out  C_y_bits  y relative to window start.
- o_osd_valid  out  1  coordinates inside the active window.
- i_osd_r, i_osd_g, i_osd_b  in  C_color_bits each  OSD colour, C_src_latency after coordinates.
- o_r, o_g, o_b  out  C_color_bits each  mixed video.
- o_hsync, o_vsync, o_blank  out  1 each  delayed timing.

Behaviour:
- Stall: every register updates only when clk_pixel_ena=1. rst overrides ena.
- Reset values:
  - o_r, o_g, o_b = 0; o_hsync = o_vsync = 0; o_blank = 1.
  - o_osd_x = o_osd_y = 0; o_osd_valid = 0.
  - x_cnt = y_cnt = 0; all delay-line contents 0, except blank taps = 1.
  - Shadow enable = 0, so no overlay appears until the first vsync rising edge after reset.
- Counters (stage 0, on input sample):
  - active = ~i_blank.
  - x_cnt increments on each active pixel and clears when blank.
  - y_cnt increments on each active-to-blank transition and clears on i_vsync rising edge.
  - Both counters saturate at all-ones; no wrap.
- Shadowing: on i_vsync rising edge, cfg_* are latched into shadow registers. Mid-frame cfg changes have no effect until the next frame.
- Window:
  - in_win = active & shadow_en & (x_start ≤ x_cnt < x_stop) & (y_start ≤ y_cnt < y_stop).
  - stop ≤ start gives an empty window; the overlay is never shown.
- Coordinates (registered, 1 cycle after input):
  - o_osd_x = x_cnt − x_start and o_osd_y = y_cnt − y_start when in_win; otherwise both 0.
  - o_osd_valid = in_win.
- Alignment: input RGB, sync, blank and in_win are delayed by 1+C_src_latency cycles; for C_src_latency = 0 the delay is 1 cycle.
- Mix register (1 cycle), applied when the delayed in_win = 1; otherwise input passes through:
  - Opaque: output = OSD colour.
  - Blend: per channel (in + osd) >> 1 using a C_color_bits+1 sum, floor.
  - Key: pass input if {osd r,g,b} == key, else OSD colour.
- Total latency, input to o_* (RGB, sync, blank alike): C_src_latency + 2 enabled cycles.
- Simultaneous vsync rising edge and active pixel: y_cnt clear wins; the shadow latch takes effect on that same pixel.
- Reset mid-frame: counters restart at 0, overlay is disabled until the next vsync, and outputs show blank until the pipeline refills.

Decomposition:
- Package osd_pkg: OSD_MODE_OPAQUE=0, OSD_MODE_BLEND=1, OSD_MODE_KEY=2 and a 2-bit mode typedef; shared with the future OSD register-file block.
- Sub-module osd_delay_line: parameters WIDTH and DEPTH (DEPTH 0 = wire), ports clk_pixel, rst, ena, RST_VALUE, in, out. One instance for {rgb, hsync, vsync, blank, in_win}.

Test Plan:
- Defaults, window x 96..120, y 96..100, opaque, en=1, OSD source returning constant 0xFF0000, with a synthetic 160x120 raster → after the first vsync, o_r=0xFF exactly at output columns 96..119 and rows 96..99, with latency 3; o_osd_x runs 0..23 per row.
- Blend mode, input 0x40, OSD 0xC1 on all channels → 0x80 inside the window; input unchanged outside.
- Key mode, key=0x000000, OSD alternating 0x000000/0x00FF00 → alternate pixels show input/green.
- cfg_en raised and cfg_x_start changed mid-frame → no change until the next vsync rising edge, then the new window applies.
- x_stop=x_start=50 → o_osd_valid never asserts; output equals input delayed 3 cycles.
- clk_pixel_ena toggling 1/0, plus rst pulsed mid-line → output sequence identical to the ena=1 run with stalled cycles removed; after rst o_blank=1, o_osd_valid=0, and no overlay until the next vsync.
